// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared encodings and defaults for the pipeline hazard/stall logic.
package pipeline_pkg;
  typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int MD_CYCLES_DEF = 4;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use and branch/jump-operand hazard detection.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [4:0] dec_rs,
  input  logic [4:0] dec_rt,
  input  logic       dec_uses_rs,
  input  logic       dec_uses_rt,
  input  logic       branch,
  input  logic       jump_reg,
  input  logic [4:0] exec_dst,
  input  logic [4:0] mem_dst,
  input  logic       exec_reg_write,
  input  logic       exec_mem_read,
  input  logic       mem_mem_read,
  output logic       load_use,
  output logic       br_haz
);
  logic rs_exec, rt_exec, rs_mem, rt_mem;
  assign rs_exec = dec_uses_rs && dec_rs == exec_dst && exec_dst != REG_ZERO;
  assign rt_exec = dec_uses_rt && dec_rt == exec_dst && exec_dst != REG_ZERO;
  assign rs_mem  = dec_uses_rs && dec_rs == mem_dst && mem_dst != REG_ZERO;
  assign rt_mem  = dec_uses_rt && dec_rt == mem_dst && mem_dst != REG_ZERO;
  assign load_use = exec_mem_read && (rs_exec || rt_exec);
  // Register jumps only read RS, so RT matches apply to conditional branches alone.
  assign br_haz = ((branch || jump_reg) && ((exec_reg_write && rs_exec) || (mem_mem_read && rs_mem)))
               || (branch && ((exec_reg_write && rt_exec) || (mem_mem_read && rt_mem)));
endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: stall/flush sequencing, mul/div occupancy FSM and stall counter.
module hazard_stall_controller
  import pipeline_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEF,
  parameter int CNT_W     = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       DecRS,
  input  logic [4:0]       DecRT,
  input  logic             DecUsesRS,
  input  logic             DecUsesRT,
  input  logic             Branch,
  input  logic             JumpReg,
  input  logic             BranchTaken,
  input  logic             DecMulDiv,
  input  logic             DecReadsHiLo,
  input  logic [4:0]       ExecDstReg,
  input  logic [4:0]       MemDstReg,
  input  logic             ExecRegWrite,
  input  logic             ExecMemRead,
  input  logic             MemMemRead,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXFlush,
  output logic             IFIDFlush,
  output logic             MulDivStart,
  output logic             MulDivBusy,
  output logic [CNT_W-1:0] StallCycles
);
  md_state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic load_use, br_haz, md_haz, stall, issue, busy;
  hazard_detect u_detect (
    .dec_rs(DecRS), .dec_rt(DecRT), .dec_uses_rs(DecUsesRS), .dec_uses_rt(DecUsesRT),
    .branch(Branch), .jump_reg(JumpReg), .exec_dst(ExecDstReg), .mem_dst(MemDstReg),
    .exec_reg_write(ExecRegWrite), .exec_mem_read(ExecMemRead), .mem_mem_read(MemMemRead),
    .load_use(load_use), .br_haz(br_haz)
  );
  assign busy   = state == MD_BUSY;
  assign md_haz = (DecReadsHiLo || DecMulDiv) && busy;
  assign stall  = load_use || br_haz || md_haz;
  assign issue  = DecMulDiv && !stall;
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      state <= MD_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  // Re-issue from BUSY is unreachable while md_haz holds, but kept for a clean transition table.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (state == MD_IDLE || cnt == 4'd0) begin
      state_nx = issue ? MD_BUSY : MD_IDLE;
      cnt_nx   = issue ? 4'(MD_CYCLES - 1) : 4'd0;
    end else
      cnt_nx = cnt - 4'd1;
  end
  always_comb begin
    PCWrite     = Rst && !stall;
    IFIDWrite   = Rst && !stall;
    IDEXFlush   = !Rst || stall;
    IFIDFlush   = !Rst || (!stall && BranchTaken);
    MulDivStart = Rst && state == MD_IDLE && issue;
    MulDivBusy  = busy;
  end
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) StallCycles <= '0;
    else if (stall) StallCycles <= StallCycles + 1'b1;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: table-driven hazard vectors plus mul/div, reset and wrap sequences.
module tb_hazard_stall_controller;
  logic Clk, Rst;
  logic [4:0] DecRS, DecRT, ExecDstReg, MemDstReg;
  logic DecUsesRS, DecUsesRT, Branch, JumpReg, BranchTaken, DecMulDiv, DecReadsHiLo;
  logic ExecRegWrite, ExecMemRead, MemMemRead;
  logic PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, MulDivStart, MulDivBusy;
  logic [3:0] StallCycles;
  logic [3:0] exp_cnt;
  int checks = 0, failures = 0;

  hazard_stall_controller #(.MD_CYCLES(4), .CNT_W(4)) dut (
    .Clk(Clk), .Rst(Rst), .DecRS(DecRS), .DecRT(DecRT), .DecUsesRS(DecUsesRS),
    .DecUsesRT(DecUsesRT), .Branch(Branch), .JumpReg(JumpReg), .BranchTaken(BranchTaken),
    .DecMulDiv(DecMulDiv), .DecReadsHiLo(DecReadsHiLo), .ExecDstReg(ExecDstReg),
    .MemDstReg(MemDstReg), .ExecRegWrite(ExecRegWrite), .ExecMemRead(ExecMemRead),
    .MemMemRead(MemMemRead), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXFlush(IDEXFlush),
    .IFIDFlush(IFIDFlush), .MulDivStart(MulDivStart), .MulDivBusy(MulDivBusy),
    .StallCycles(StallCycles)
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic [4:0] rs, rt, ed, md;
    logic urs, urt, br, jr, tk, erw, emr, mmr, stall, iflush;
  } vec_t;
  vec_t v[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    {DecRS, DecRT, ExecDstReg, MemDstReg} = '0;
    {DecUsesRS, DecUsesRT, Branch, JumpReg, BranchTaken, DecMulDiv, DecReadsHiLo} = '0;
    {ExecRegWrite, ExecMemRead, MemMemRead} = '0;
  endtask

  task automatic load_use_on();
    DecRS = 5'd2; DecUsesRS = 1'b1; ExecDstReg = 5'd2; ExecMemRead = 1'b1; ExecRegWrite = 1'b1;
  endtask

  initial begin
    int n;
    bit done;
    //        rs     rt     ed     md    urs   urt   br    jr    tk    erw   emr   mmr   stall iflush
    v[0]  = '{5'd2, 5'd0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    v[1]  = '{5'd5, 5'd2, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    v[2]  = '{5'd2, 5'd0, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    v[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    v[4]  = '{5'd2, 5'd0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    v[5]  = '{5'd3, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    v[6]  = '{5'd1, 5'd4, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    v[7]  = '{5'd3, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    v[8]  = '{5'd1, 5'd6, 5'd6, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    v[9]  = '{5'd6, 5'd0, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    v[10] = '{5'd3, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    v[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    v[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    clr();
    Rst = 1'b0;
    exp_cnt = 4'd0;
    #3;
    chk("rst_pcwrite", PCWrite, 0);
    chk("rst_ifidwrite", IFIDWrite, 0);
    chk("rst_idexflush", IDEXFlush, 1);
    chk("rst_ifidflush", IFIDFlush, 1);
    chk("rst_busy", MulDivBusy, 0);
    chk("rst_start", MulDivStart, 0);
    chk("rst_cnt", StallCycles, 0);
    tick();
    tick();
    Rst = 1'b1;
    for (int i = 0; i < 13; i++) begin
      DecRS = v[i].rs; DecRT = v[i].rt; ExecDstReg = v[i].ed; MemDstReg = v[i].md;
      DecUsesRS = v[i].urs; DecUsesRT = v[i].urt; Branch = v[i].br; JumpReg = v[i].jr;
      BranchTaken = v[i].tk; ExecRegWrite = v[i].erw; ExecMemRead = v[i].emr; MemMemRead = v[i].mmr;
      #2;
      chk($sformatf("v%0d_pcwrite", i), PCWrite, !v[i].stall);
      chk($sformatf("v%0d_ifidwrite", i), IFIDWrite, !v[i].stall);
      chk($sformatf("v%0d_idexflush", i), IDEXFlush, v[i].stall);
      chk($sformatf("v%0d_ifidflush", i), IFIDFlush, v[i].iflush);
      tick();
      if (v[i].stall) exp_cnt++;
      chk($sformatf("v%0d_cnt", i), StallCycles, exp_cnt);
    end
    // mult held off by a load-use, then issued, then mfhi waits out the unit
    clr();
    load_use_on();
    DecMulDiv = 1'b1;
    #2;
    chk("md_lu_start", MulDivStart, 0);
    chk("md_lu_pcwrite", PCWrite, 0);
    tick();
    exp_cnt++;
    clr();
    DecMulDiv = 1'b1;
    #2;
    chk("md_start", MulDivStart, 1);
    chk("md_issue_busy", MulDivBusy, 0);
    chk("md_issue_pcwrite", PCWrite, 1);
    tick();
    DecMulDiv = 1'b0;
    DecReadsHiLo = 1'b1;
    n = 0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      #2;
      chk("md_busy_vs_stall", MulDivBusy, !PCWrite);
      chk("md_start_once", MulDivStart, 0);
      if (PCWrite) done = 1;
      else begin
        n++;
        tick();
      end
    end
    chk("md_done", done, 1);
    chk("md_stall_len", n, 4);
    exp_cnt += 4'(n);
    chk("md_cnt", StallCycles, exp_cnt);
    tick();
    // asynchronous reset between edges while the unit is busy
    clr();
    DecMulDiv = 1'b1;
    #2;
    chk("rb_start", MulDivStart, 1);
    tick();
    DecMulDiv = 1'b0;
    #2;
    chk("rb_busy_before", MulDivBusy, 1);
    #2;
    Rst = 1'b0;
    #1;
    chk("rb_busy", MulDivBusy, 0);
    chk("rb_ifidflush", IFIDFlush, 1);
    chk("rb_pcwrite", PCWrite, 0);
    chk("rb_cnt", StallCycles, 0);
    #1;
    Rst = 1'b1;
    exp_cnt = 4'd0;
    DecReadsHiLo = 1'b1;
    #1;
    chk("rb_mfhi_pcwrite", PCWrite, 1);
    tick();
    chk("rb_mfhi_busy", MulDivBusy, 0);
    chk("rb_mfhi_cnt", StallCycles, 0);
    // counter wrap with a 4-bit counter
    clr();
    load_use_on();
    repeat (15) tick();
    chk("wrap_15", StallCycles, 15);
    tick();
    chk("wrap_0", StallCycles, 0);
    clr();
    #2;
    chk("wrap_release_pcwrite", PCWrite, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Pipeline sequencing controller for the 5-stage MIPS datapath; sits beside the forwarding controller and covers the hazards that forwarding cannot resolve. Detects load-use and branch/jump-operand hazards and drives PC/IF-ID write enables, ID/EX bubble insertion and IF/ID flush. Owns the occupancy FSM for the multi-cycle multiply/divide unit, stalls HI/LO consumers until it completes, and keeps a stall-cycle performance counter.

Parameters:
MD_CYCLES, 4, execute cycles of the mul/div unit after issue (valid range 2..15)
CNT_W, 32, width of the stall performance counter

Ports:
Clk  input  1  clock, all state updates on rising edge
Rst  input  1  reset, asynchronous, active-low
DecRS, DecRT  input  5  source register numbers of the instruction in Decode
DecUsesRS, DecUsesRT  input  1  Decode instruction actually reads RS / RT
Branch, JumpReg  input  1  Decode holds a conditional branch / register jump (jr, jalr)
BranchTaken  input  1  branch/jump resolved taken in Decode
DecMulDiv  input  1  Decode holds mult/multu/div/divu
DecReadsHiLo  input  1  Decode holds mfhi/mflo
ExecDstReg, MemDstReg  input  5  destination register in Exec / Mem
ExecRegWrite, ExecMemRead, MemMemRead  input  1  Exec writes a reg / Exec is a load / Mem is a load
PCWrite  output  1  PC load enable
IFIDWrite  output  1  IF/ID register load enable
IDEXFlush  output  1  insert bubble into ID/EX
IFIDFlush  output  1  squash fetched instruction
MulDivStart  output  1  one-cycle issue pulse to the mul/div unit
MulDivBusy  output  1  mul/div result not yet valid
StallCycles  output  CNT_W  count of cycles with Stall asserted

Behaviour:
- Register 0 never causes a hazard. RSmatch(X) = DecUsesRS && DecRS==X && X!=0; likewise RTmatch.
- LoadUse = ExecMemRead && (RSmatch(ExecDstReg) || RTmatch(ExecDstReg)).
- BrHaz = (Branch||JumpReg) && [ (ExecRegWrite && match(ExecDstReg)) || (MemMemRead && match(MemDstReg)) ]; JumpReg considers RS only. A load feeding a branch therefore stalls 2 cycles and an ALU result feeding a branch stalls 1 cycle.
- MDHaz = (DecReadsHiLo || DecMulDiv) && MulDivBusy.
- Stall = LoadUse || BrHaz || MDHaz. Combinational; re-evaluated every cycle.
- Stall=1: PCWrite=0, IFIDWrite=0, IDEXFlush=1, IFIDFlush=0. BranchTaken is ignored, because operands are not valid.
- Stall=0: PCWrite=1, IFIDWrite=1, IDEXFlush=0, IFIDFlush=BranchTaken.
- Mul/div FSM states: IDLE, BUSY.
  - IDLE -> BUSY when DecMulDiv && !Stall. MulDivStart=1 in that cycle only; counter loads MD_CYCLES-1.
  - BUSY: counter decrements each cycle. At 0 go to IDLE, or re-issue directly if a new DecMulDiv is present and not stalled (never, because MDHaz blocks it; IDLE is always visited for one cycle).
  - MulDivBusy=1 in BUSY. The first mfhi is unstalled in the cycle after the counter reaches 0.
  - Net effect: an mfhi directly after mult stalls exactly MD_CYCLES cycles.
- StallCycles increments by 1 on each rising edge where Stall=1. Wraps modulo 2^CNT_W with no saturation.
- Reset (Rst=0, asynchronous):
  - FSM to IDLE, counter 0, StallCycles 0, MulDivBusy 0, MulDivStart 0.
  - While Rst=0: PCWrite=0, IFIDWrite=0, IDEXFlush=1, IFIDFlush=1, so the pipeline is held empty.
  - Reset mid-BUSY abandons the operation. The first edge after release behaves as IDLE.
- Simultaneous events:
  - LoadUse and BrHaz together give a single stall, and the counter increments once.
  - DecMulDiv together with LoadUse: no issue; MulDivStart is held off until Stall drops.

Decomposition:
- Shared package (pipeline_pkg): MD state encoding (IDLE=1'b0, BUSY=1'b1), register-zero constant, default MD_CYCLES.
- One sub-module: hazard_detect. Purely combinational; computes LoadUse, BrHaz and the match terms.
- Top level holds the FSM, counters and output muxing.

Test Plan:
- lw $2 in Exec (ExecDstReg=2, ExecMemRead=1); add in Dec with DecRS=2 -> exactly 1 cycle PCWrite=0, IDEXFlush=1; StallCycles 0->1; next cycle PCWrite=1.
- beq with DecRS=3; lw $3 in Exec -> stalled 2 consecutive cycles (Exec, then Mem match); BranchTaken=1 is ignored until the 3rd cycle, then IFIDFlush=1 for 1 cycle.
- mult issued (MD_CYCLES=4), then mfhi next cycle -> MulDivStart pulse of 1 cycle; mfhi stalled 4 cycles; MulDivBusy falls in the same cycle Stall drops; StallCycles=4.
- add $0 in Exec as a load-type write with DecRS=0 -> no stall; PCWrite stays 1.
- Assert Rst=0 asynchronously mid-BUSY (between edges) -> MulDivBusy=0 and IFIDFlush=1 immediately; after release, mfhi in Dec does not stall.
- Force 2^CNT_W stall cycles with CNT_W=4 -> StallCycles wraps 15->0.
